bram_stream_reader: RTL and testbench

// - Read-side master for bram_sdp: on a start command, reads LEN consecutive words from

---
 rtl/bram_stream_reader_pkg.sv | 8 +
 rtl/bram_stream_reader_if.sv | 12 +
 rtl/bram_stream_reader_fifo_2deep.sv | 37 +++
 rtl/bram_stream_reader.sv | 108 ++++++++++
 tb/tb_bram_stream_reader.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/bram_stream_reader_pkg.sv
// Shared defaults and small types for the BRAM stream reader slice.
package bram_stream_reader_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 256;

  // Occupancy of the 2-entry output buffer (0..2).
  typedef logic [1:0] fifo_cnt_t;
endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream with a last-beat flag.
interface bram_stream_reader_if #(
  parameter int WIDTH = bram_stream_reader_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/bram_stream_reader_fifo_2deep.sv
// Two-entry FIFO; push while full is legal when a pop happens in the same cycle.
module fifo_2deep
  import bram_stream_reader_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output fifo_cnt_t    count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + fifo_cnt_t'(push) - fifo_cnt_t'(pop);
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/bram_stream_reader.sv
// Reads LEN consecutive BRAM words from BASE and streams them out with a last flag.
//   state   | meaning
//   S_IDLE  | waiting for start; zero-length command pulses done directly
//   S_READ  | issuing BRAM reads while the buffer has room
//   S_DRAIN | all reads issued; waiting for the last beat to be accepted
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDRW-1:0]    base,
  input  logic [ADDRW:0]      len,
  output logic                busy,
  output logic                done,
  output logic [ADDRW-1:0]    bram_addr,
  input  logic [WIDTH-1:0]    bram_data,
  bram_stream_reader_if.master m
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [ADDRW:0]   remain;
  logic [ADDRW-1:0] addr_q;
  logic             rd_pend;
  logic             rd_last_pend;
  logic             done_q;
  fifo_cnt_t        fcount;
  logic [WIDTH:0]   fifo_out;
  logic             pop;
  logic [2:0]       occ;
  logic             issue;
  logic             issue_last;
  logic [ADDRW-1:0] addr_next;

  assign pop        = m.valid && m.ready;
  // Slots that will be taken after this edge: buffered + the read in flight - the beat leaving now.
  assign occ        = 3'(fcount) + 3'(rd_pend) - 3'(pop);
  assign issue      = (state == S_READ) && (remain != '0) && (occ < 3'd2);
  assign issue_last = (remain == (ADDRW+1)'(1));
  assign addr_next  = (addr_q == ADDRW'(DEPTH-1)) ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      remain       <= '0;
      addr_q       <= '0;
      rd_pend      <= 1'b0;
      rd_last_pend <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      rd_pend      <= issue;
      rd_last_pend <= issue && issue_last;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state  <= S_READ;
              addr_q <= base;
              remain <= len;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (issue) begin
            remain <= remain - 1'b1;
            // Address stays on the final word once everything is issued.
            if (issue_last) state  <= S_DRAIN;
            else            addr_q <= addr_next;
          end
        end
        S_DRAIN: begin
          if (pop && m.last) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fifo_2deep #(.W(WIDTH + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pend),
    .din   ({rd_last_pend, bram_data}),
    .pop   (pop),
    .dout  (fifo_out),
    .count (fcount)
  );

  assign m.valid   = (fcount != '0);
  assign m.data    = fifo_out[WIDTH-1:0];
  assign m.last    = m.valid && fifo_out[WIDTH];
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign bram_addr = addr_q;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a behavioural 16x8 BRAM holding mem[i]=i.
module tb_bram_stream_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int ADDRW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [ADDRW-1:0] base = '0;
  logic [ADDRW:0]   len = '0;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] bram_addr;
  logic [WIDTH-1:0] bram_data;

  bram_stream_reader_if #(.WIDTH(WIDTH)) m ();

  bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .bram_addr (bram_addr),
    .bram_data (bram_data),
    .m         (m)
  );

  always #5 clk = ~clk;

  // BRAM model: one-cycle registered read, contents equal to address.
  logic [WIDTH-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
  always @(posedge clk) bram_data <= mem[bram_addr];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat collector and stall-stability monitor, sampled mid-cycle.
  logic [8:0] beats [$];
  int         done_cnt = 0;
  logic       stalled = 1'b0;
  logic [8:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(m.valid), 32'd1);
        chk("stall_hold", 32'({m.last, m.data}), 32'(held));
      end
      if (done) done_cnt++;
      if (m.valid && m.ready) beats.push_back({m.last, m.data});
      stalled = m.valid && !m.ready;
      held    = {m.last, m.data};
    end
  end

  task automatic run_cmd(input logic [3:0] b, input logic [4:0] l, input bit rnd,
                         input bit restart, input string tag);
    bit         seen;
    logic [3:0] a;
    beats.delete();
    done_cnt = 0;
    base  = b;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen  = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      m.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (restart && cyc == 3) begin
        base  = 4'd9;
        len   = 5'd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        seen = 1'b1;
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      end
    end
    start   = 1'b0;
    m.ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) tick();
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_beat_count"}, 32'(beats.size()), 32'(l));
    chk({tag, "_idle_valid"}, 32'(m.valid), 32'd0);
    for (int i = 0; i < beats.size() && i < int'(l); i++) begin
      a = b + 4'(i);
      chk({tag, "_beat"}, 32'(beats[i]), 32'({(i == int'(l) - 1), 4'b0000, a}));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m.ready = 1'b1;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(m.valid), 32'd0);
    chk("rst_last", 32'(m.last), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_data", 32'(m.data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // base=2 len=4 full rate: exact cycle timing.
    base  = 4'd2;
    len   = 5'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_addr_c1", 32'(bram_addr), 32'd2);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    tick();
    chk("t1_valid_c2", 32'(m.valid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", 32'(m.valid), 32'd1);
      chk("t1_data", 32'(m.data), 32'(2 + i));
      chk("t1_last", 32'(m.last), 32'(i == 3));
      chk("t1_done_early", 32'(done), 32'd0);
      tick();
    end
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_valid_end", 32'(m.valid), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // Zero-length command.
    base  = 4'd7;
    len   = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_valid", 32'(m.valid), 32'd0);
    tick();
    chk("len0_done_pulse", 32'(done), 32'd0);
    chk("len0_valid2", 32'(m.valid), 32'd0);

    run_cmd(4'd14, 5'd4, 1'b0, 1'b0, "wrap");
    run_cmd(4'd0, 5'd16, 1'b1, 1'b0, "rand");
    run_cmd(4'd3, 5'd6, 1'b0, 1'b1, "busy_start");

    // Reset after two of eight beats.
    beats.delete();
    done_cnt = 0;
    base  = 4'd0;
    len   = 5'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && beats.size() < 2; c++) tick();
    m.ready = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_valid", 32'(m.valid), 32'd0);
    chk("mid_rst_last", 32'(m.last), 32'd0);
    chk("mid_rst_addr", 32'(bram_addr), 32'd0);
    chk("mid_rst_data", 32'(m.data), 32'd0);
    tick();
    rst_n   = 1'b1;
    m.ready = 1'b1;
    repeat (10) tick();
    chk("mid_rst_beats", 32'(beats.size()), 32'd2);
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    if (beats.size() >= 2) begin
      chk("mid_rst_beat0", 32'(beats[0]), 32'h000);
      chk("mid_rst_beat1", 32'(beats[1]), 32'h001);
    end
    run_cmd(4'd5, 5'd3, 1'b0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
